fpu_stream_ctl: RTL and testbench

Streaming front/back-end wrapper for the FP16 FMA pipeline (fpu1 -> fpu2 -> fpu3, op fixed to FMA).
- Accepts operand triples over a valid/ready handshake and drives them into fpu1's ex1/ex2/ex3.
- Tracks in-flight valid bits alongside the 2-register datapath.
- Captures fpu3's combinational result exd into an output FIFO with its own valid/ready handshake, using credit-based backpressure so no result is ever dropped.

---
 rtl/fpu_stream_ctl.sv | 119 +++++++++++
 tb/tb_fpu_stream_ctl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_stream_ctl.sv
// Streaming wrapper around the three-stage FP16 FMA pipeline (fpu1 -> fpu2 -> fpu3).
// Operand triples enter over a valid/ready handshake. Results land in a small FIFO.
// A credit check counts FIFO occupancy plus in-flight results, so a push never finds the FIFO full.
module fpu_stream_ctl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          ACLK,
    input  logic                          RSTN,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [15:0]                   in_op1,
    input  logic [15:0]                   in_op2,
    input  logic [15:0]                   in_op3,
    output logic [15:0]                   fpu_ex1,
    output logic [15:0]                   fpu_ex2,
    output logic [15:0]                   fpu_ex3,
    output logic                          fpu_force0,
    input  logic [15:0]                   fpu_exd,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [15:0]                   out_data,
    output logic [$clog2(FIFO_DEPTH):0]   out_count,
    output logic [1:0]                    inflight,
    output logic [CNT_W-1:0]              done_cnt
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned CsW  = PtrW + 2;

    logic [1:0]      vld_sr_q;
    logic [15:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;
    logic [CNT_W-1:0] done_cnt_q;
    logic [CsW-1:0]  credit_sum;
    logic            acc;
    logic            push;
    logic            pop;

    // Handshake, credit check and operand drive; in_ready depends on registered state only.
    always_comb begin
        credit_sum = {1'b0, count_q} + {{PtrW{1'b0}}, inflight};
        in_ready   = credit_sum < CsW'(FIFO_DEPTH);
        acc        = in_valid & in_ready;
        fpu_ex1    = acc ? in_op1 : 16'h0000;
        fpu_ex2    = acc ? in_op2 : 16'h0000;
        fpu_ex3    = acc ? in_op3 : 16'h0000;
        fpu_force0 = 1'b0;
        push       = vld_sr_q[1];
        pop        = out_valid & out_ready;
    end

    // Output views of the registered state.
    always_comb begin
        inflight  = {1'b0, vld_sr_q[0]} + {1'b0, vld_sr_q[1]};
        out_valid = (count_q != '0);
        out_data  = mem_q[rd_ptr_q];
        out_count = count_q;
        done_cnt  = done_cnt_q;
    end

    // Occupancy next state; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Valid bits shadowing the two fpu pipeline registers.
    always_ff @(posedge ACLK or negedge RSTN) begin
        if (!RSTN) begin
            vld_sr_q <= 2'b00;
        end else begin
            vld_sr_q <= {vld_sr_q[0], acc};
        end
    end

    // Result FIFO storage and pointers; storage is cleared so out_data reads zero after reset.
    always_ff @(posedge ACLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 16'h0000;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= fpu_exd;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    // Count of delivered results, wrapping naturally.
    always_ff @(posedge ACLK or negedge RSTN) begin
        if (!RSTN) begin
            done_cnt_q <= '0;
        end else if (pop) begin
            done_cnt_q <= done_cnt_q + CNT_W'(1);
        end
    end

    // The credit check must make a push into a full FIFO unreachable.
    assert property (@(posedge ACLK) disable iff (!RSTN)
        !(push && (count_q == CntW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fpu_stream_ctl.sv
// Directed bench for fpu_stream_ctl with a stand-in two-register FMA pipeline.
module tb_fpu_stream_ctl;

    logic        ACLK;
    logic        RSTN;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_op1;
    logic [15:0] in_op2;
    logic [15:0] in_op3;
    logic [15:0] fpu_ex1;
    logic [15:0] fpu_ex2;
    logic [15:0] fpu_ex3;
    logic        fpu_force0;
    logic [15:0] fpu_exd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_count;
    logic [1:0]  inflight;
    logic [15:0] done_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q [$];
    logic [47:0] vec [6];
    logic [47:0] s2;
    logic [47:0] s3;

    fpu_stream_ctl #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .ACLK       (ACLK),
        .RSTN       (RSTN),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op1     (in_op1),
        .in_op2     (in_op2),
        .in_op3     (in_op3),
        .fpu_ex1    (fpu_ex1),
        .fpu_ex2    (fpu_ex2),
        .fpu_ex3    (fpu_ex3),
        .fpu_force0 (fpu_force0),
        .fpu_exd    (fpu_exd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .inflight   (inflight),
        .done_cnt   (done_cnt)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Hand-computed FP16 a*b+c for the operand triples used here.
    function automatic logic [15:0] fma_ref(input logic [47:0] t);
        case (t)
            {16'h3C00, 16'h3C00, 16'h3C00}: fma_ref = 16'h4000;
            {16'h4000, 16'h4000, 16'h4000}: fma_ref = 16'h4600;
            {16'h0000, 16'h0000, 16'h0000}: fma_ref = 16'h0000;
            {16'h3C00, 16'h4000, 16'h3C00}: fma_ref = 16'h4200;
            {16'h4000, 16'h4000, 16'h0000}: fma_ref = 16'h4400;
            {16'h3C00, 16'h3C00, 16'h0000}: fma_ref = 16'h3C00;
            default:                        fma_ref = 16'hFFFF;
        endcase
    endfunction

    // Stand-in for fpu1/fpu2 registers, with fpu3 combinational, sharing RSTN.
    always_ff @(posedge ACLK or negedge RSTN) begin
        if (!RSTN) begin
            s2 <= '0;
            s3 <= '0;
        end else begin
            s2 <= {fpu_ex1, fpu_ex2, fpu_ex3};
            s3 <= s2;
        end
    end
    assign fpu_exd = fma_ref(s3);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic [47:0] t);
        in_op1 = t[47:32];
        in_op2 = t[31:16];
        in_op3 = t[15:0];
    endtask

    // Scoreboard: record accepts, compare every pop in order, flag outputs with nothing pending.
    always @(negedge ACLK) begin
        if (RSTN) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", {31'b0, out_valid}, 32'd0);
            end else if (out_valid && out_ready) begin
                check_eq("out_data", {16'b0, out_data}, {16'b0, exp_q.pop_front()});
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(fma_ref({in_op1, in_op2, in_op3}));
            end
            check_eq("count_max", {31'b0, out_count <= 3'd4}, 32'd1);
        end
    end

    always @(negedge RSTN) exp_q.delete();

    int n_acc;
    int sel;

    initial begin
        vec[0] = {16'h3C00, 16'h3C00, 16'h3C00};
        vec[1] = {16'h4000, 16'h4000, 16'h4000};
        vec[2] = {16'h0000, 16'h0000, 16'h0000};
        vec[3] = {16'h3C00, 16'h4000, 16'h3C00};
        vec[4] = {16'h4000, 16'h4000, 16'h0000};
        vec[5] = {16'h3C00, 16'h3C00, 16'h0000};
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_ops('0);
        RSTN = 1'b0;

        // 1: reset values
        repeat (4) @(posedge ACLK);
        #1 RSTN = 1'b1;
        @(negedge ACLK);
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_out_count", {29'b0, out_count}, 32'd0);
        check_eq("rst_inflight", {30'b0, inflight}, 32'd0);
        check_eq("rst_done_cnt", {16'b0, done_cnt}, 32'd0);
        check_eq("rst_out_data", {16'b0, out_data}, 32'd0);
        check_eq("force0", {31'b0, fpu_force0}, 32'd0);

        // 2: single op, latency 3
        @(posedge ACLK); #1;
        in_valid = 1'b1; out_ready = 1'b1; set_ops(vec[0]);
        @(negedge ACLK);
        check_eq("t2_ex1", {16'b0, fpu_ex1}, 32'h3C00);
        check_eq("t2_ex3", {16'b0, fpu_ex3}, 32'h3C00);
        @(posedge ACLK); #1;
        in_valid = 1'b0;
        @(negedge ACLK);
        check_eq("t2_inflight_t1", {30'b0, inflight}, 32'd1);
        check_eq("t2_bubble_ex2", {16'b0, fpu_ex2}, 32'd0);
        @(negedge ACLK);
        check_eq("t2_inflight_t2", {30'b0, inflight}, 32'd1);
        check_eq("t2_valid_t2", {31'b0, out_valid}, 32'd0);
        @(negedge ACLK);
        check_eq("t2_valid_t3", {31'b0, out_valid}, 32'd1);
        check_eq("t2_data_t3", {16'b0, out_data}, 32'h4000);
        @(negedge ACLK);
        check_eq("t2_done_cnt", {16'b0, done_cnt}, 32'd1);
        check_eq("t2_valid_t4", {31'b0, out_valid}, 32'd0);

        // 3: back-to-back stream, results on consecutive cycles
        for (int i = 0; i < 4; i++) begin
            @(posedge ACLK); #1;
            in_valid = 1'b1;
            set_ops(vec[(i == 3) ? 0 : i]);
            @(negedge ACLK);
            check_eq("t3_in_ready", {31'b0, in_ready}, 32'd1);
        end
        check_eq("t3_valid_first", {31'b0, out_valid}, 32'd1);
        @(posedge ACLK); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check_eq("t3_valid_run", {31'b0, out_valid}, 32'd1);
        end
        @(negedge ACLK);
        check_eq("t3_valid_end", {31'b0, out_valid}, 32'd0);
        check_eq("t3_done_cnt", {16'b0, done_cnt}, 32'd5);

        // 4: backpressure, exactly FIFO_DEPTH accepts
        n_acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge ACLK); #1;
            out_ready = 1'b0; in_valid = 1'b1;
            set_ops(vec[3 + (n_acc % 3)]);
            @(negedge ACLK);
            if (in_ready) n_acc++;
        end
        check_eq("t4_accepts", n_acc, 32'd4);
        check_eq("t4_in_ready", {31'b0, in_ready}, 32'd0);
        check_eq("t4_out_count", {29'b0, out_count}, 32'd4);
        check_eq("t4_inflight", {30'b0, inflight}, 32'd0);
        @(posedge ACLK); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(negedge ACLK);
        check_eq("t4_drained", {29'b0, out_count}, 32'd0);
        check_eq("t4_in_ready_back", {31'b0, in_ready}, 32'd1);
        check_eq("t4_done_cnt", {16'b0, done_cnt}, 32'd9);

        // 5: toggling out_ready with 20 random triples
        n_acc = 0;
        sel = $urandom_range(0, 5);
        for (int c = 0; c < 200 && n_acc < 20; c++) begin
            @(posedge ACLK); #1;
            out_ready = c[0]; in_valid = 1'b1;
            set_ops(vec[sel]);
            @(negedge ACLK);
            if (in_ready) begin
                n_acc++;
                sel = $urandom_range(0, 5);
            end
        end
        check_eq("t5_accepts", n_acc, 32'd20);
        @(posedge ACLK); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(negedge ACLK);
        check_eq("t5_done_cnt", {16'b0, done_cnt}, 32'd29);
        check_eq("t5_out_count", {29'b0, out_count}, 32'd0);

        // 6: asynchronous reset with results in flight and buffered
        for (int i = 0; i < 4; i++) begin
            @(posedge ACLK); #1;
            out_ready = 1'b0; in_valid = 1'b1;
            set_ops(vec[i]);
        end
        @(posedge ACLK); #1;
        in_valid = 1'b0;
        @(negedge ACLK);
        check_eq("t6_pre_inflight", {30'b0, inflight}, 32'd2);
        check_eq("t6_pre_count", {29'b0, out_count}, 32'd2);
        #2 RSTN = 1'b0;
        #1;
        check_eq("t6_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("t6_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("t6_out_count", {29'b0, out_count}, 32'd0);
        check_eq("t6_inflight", {30'b0, inflight}, 32'd0);
        check_eq("t6_done_cnt", {16'b0, done_cnt}, 32'd0);
        check_eq("t6_out_data", {16'b0, out_data}, 32'd0);
        repeat (3) @(posedge ACLK);
        #1 RSTN = 1'b1; out_ready = 1'b1;
        repeat (8) @(negedge ACLK);
        check_eq("t6_post_count", {29'b0, out_count}, 32'd0);
        check_eq("t6_post_done", {16'b0, done_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
